// File: rtl/dds_ctrl_pkg.sv
// Shared types and helpers for the DDS front-panel tuning controller.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  typedef enum logic [2:0] {
    IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR
  } quad_state_t;

  // Packed board-input vector: {Rot_A, Rot_B, BTN_step, BTN_mode[3:0]}
  localparam int NUM_IN   = 7;
  localparam int IN_ROT_A = 6;
  localparam int IN_ROT_B = 5;
  localparam int IN_STEP  = 4;
  localparam logic [NUM_IN-1:0] SYNC_RST = 7'b110_0000;

  function automatic logic [63:0] step_inc(input logic [2:0] idx, input int shift);
    return 64'd1 << (shift * int'(idx));
  endfunction

endpackage

// File: rtl/dds_tuning_ctrl_if.sv
// Board-side panel signals and DDS-side configuration outputs of the tuning controller.
interface dds_tuning_ctrl_if #(parameter int FTW_W = 32);
  logic [3:0]       input_BTN_mode;
  logic             input_BTN_step;
  logic             input_Rot_A;
  logic             input_Rot_B;
  logic [FTW_W-1:0] output_ftw;
  logic [1:0]       output_wave_sel;
  logic [2:0]       output_step_idx;
  logic             output_cfg_valid;

  modport master (
    output input_BTN_mode, input_BTN_step, input_Rot_A, input_Rot_B,
    input  output_ftw, output_wave_sel, output_step_idx, output_cfg_valid
  );

  modport slave (
    input  input_BTN_mode, input_BTN_step, input_Rot_A, input_Rot_B,
    output output_ftw, output_wave_sel, output_step_idx, output_cfg_valid
  );
endinterface

// File: rtl/dds_quad_decoder.sv
// Quadrature detent decoder: synchronised A/B in, one-cycle registered inc/dec pulse per full detent.
module dds_quad_decoder
  import dds_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic b_i,
  output logic inc_o,
  output logic dec_o
);

  quad_state_t state_q, state_d;
  logic        inc_d, dec_d, inc_q, dec_q;
  logic [1:0]  ab;

  assign ab = {a_i, b_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  // Single-bit moves step forward/back along the detent; any two-bit jump is illegal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: case (ab)
        2'b01:   state_d = CW1;
        2'b10:   state_d = CCW1;
        2'b00:   state_d = ERR;
        default: state_d = IDLE;
      endcase
      CW1: case (ab)
        2'b00:   state_d = CW2;
        2'b11:   state_d = IDLE;
        2'b10:   state_d = ERR;
        default: state_d = CW1;
      endcase
      CW2: case (ab)
        2'b10:   state_d = CW3;
        2'b01:   state_d = CW1;
        2'b11:   state_d = ERR;
        default: state_d = CW2;
      endcase
      CW3: case (ab)
        2'b11:   state_d = IDLE;
        2'b00:   state_d = CW2;
        2'b01:   state_d = ERR;
        default: state_d = CW3;
      endcase
      CCW1: case (ab)
        2'b00:   state_d = CCW2;
        2'b11:   state_d = IDLE;
        2'b01:   state_d = ERR;
        default: state_d = CCW1;
      endcase
      CCW2: case (ab)
        2'b01:   state_d = CCW3;
        2'b10:   state_d = CCW1;
        2'b11:   state_d = ERR;
        default: state_d = CCW2;
      endcase
      CCW3: case (ab)
        2'b11:   state_d = IDLE;
        2'b00:   state_d = CCW2;
        2'b10:   state_d = ERR;
        default: state_d = CCW3;
      endcase
      ERR:     if (ab == 2'b11) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inc_d = (state_q == CW3)  && (ab == 2'b11);
    dec_d = (state_q == CCW3) && (ab == 2'b11);
  end

  assign inc_o = inc_q;
  assign dec_o = dec_q;

endmodule

// File: rtl/dds_tuning_ctrl.sv
// DDS front-panel controller: encoder/buttons -> tuning word, step size, waveform select.
// Optional input debouncing is enabled by defining DDS_CTRL_DEBOUNCE_EN.
module dds_tuning_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int               FTW_W        = 32,
  parameter logic [FTW_W-1:0] FTW_INIT     = FTW_W'(159073),
  parameter logic [FTW_W-1:0] FTW_MIN      = FTW_W'(1),
  parameter logic [FTW_W-1:0] FTW_MAX      = {1'b0, {(FTW_W-1){1'b1}}},
  parameter int               STEP_LEVELS  = 8,
  parameter int               STEP_SHIFT   = 2,
  parameter int               DEBOUNCE_CYC = 270
) (
  input logic              input_clk_27M,
  input logic              input_RESET_n,
  dds_tuning_ctrl_if.slave bus
);

`ifdef DDS_CTRL_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [NUM_IN-1:0] raw, sync1_q, sync2_q, clean;

  assign raw = {bus.input_Rot_A, bus.input_Rot_B, bus.input_BTN_step, bus.input_BTN_mode};

  always_ff @(posedge input_clk_27M or negedge input_RESET_n) begin
    if (!input_RESET_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer flips its output after DEBOUNCE_CYC consecutive samples that disagree with it.
  generate
    if (DB_EN) begin : g_db_on
      localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
      for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;
        always_ff @(posedge input_clk_27M or negedge input_RESET_n) begin
          if (!input_RESET_n) begin
            cnt_q <= '0;
            db_q  <= SYNC_RST[i];
          end else if (sync2_q[i] == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt_q <= '0;
            db_q  <= sync2_q[i];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        assign clean[i] = db_q;
      end
    end else begin : g_db_off
      assign clean = sync2_q;
    end
  endgenerate

  logic inc_evt, dec_evt;

  dds_quad_decoder u_quad (
    .clk_i  (input_clk_27M),
    .rst_ni (input_RESET_n),
    .a_i    (clean[IN_ROT_A]),
    .b_i    (clean[IN_ROT_B]),
    .inc_o  (inc_evt),
    .dec_o  (dec_evt)
  );

  // Button events are registered so they line up with the decoder's registered pulses.
  logic [IN_STEP:0] btn_prev_q;
  logic             step_evt_q;
  logic [3:0]       mode_rise_q;

  always_ff @(posedge input_clk_27M or negedge input_RESET_n) begin
    if (!input_RESET_n) begin
      btn_prev_q  <= '0;
      step_evt_q  <= 1'b0;
      mode_rise_q <= '0;
    end else begin
      btn_prev_q  <= clean[IN_STEP:0];
      step_evt_q  <= clean[IN_STEP] & ~btn_prev_q[IN_STEP];
      mode_rise_q <= clean[3:0] & ~btn_prev_q[3:0];
    end
  end

  logic [FTW_W-1:0] ftw_q, ftw_d;
  logic [2:0]       step_q, step_d;
  wave_t            wave_q, wave_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [FTW_W:0]   inc_x, sum_x, diff_x;

  localparam logic [FTW_W:0] MIN_X = {1'b0, FTW_MIN};
  localparam logic [FTW_W:0] MAX_X = {1'b0, FTW_MAX};

  // Extra top bit catches overflow on add and borrow on subtract before clamping.
  always_comb begin
    inc_x  = (FTW_W+1)'(step_inc(step_q, STEP_SHIFT));
    sum_x  = {1'b0, ftw_q} + inc_x;
    diff_x = {1'b0, ftw_q} - inc_x;

    ftw_d = ftw_q;
    if (inc_evt)
      ftw_d = (sum_x > MAX_X) ? FTW_MAX : sum_x[FTW_W-1:0];
    else if (dec_evt)
      ftw_d = (diff_x[FTW_W] || diff_x < MIN_X) ? FTW_MIN : diff_x[FTW_W-1:0];

    step_d = step_q;
    if (step_evt_q)
      step_d = (step_q == 3'(STEP_LEVELS - 1)) ? 3'd0 : step_q + 3'd1;

    wave_d = wave_q;
    for (int k = 3; k >= 0; k--)
      if (mode_rise_q[k]) wave_d = wave_t'(k[1:0]);

    cfg_valid_d = (ftw_d != ftw_q) || (step_d != step_q) || (wave_d != wave_q);
  end

  always_ff @(posedge input_clk_27M or negedge input_RESET_n) begin
    if (!input_RESET_n) begin
      ftw_q       <= FTW_INIT;
      step_q      <= 3'd0;
      wave_q      <= WAVE_SINE;
      cfg_valid_q <= 1'b0;
    end else begin
      ftw_q       <= ftw_d;
      step_q      <= step_d;
      wave_q      <= wave_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign bus.output_ftw       = ftw_q;
  assign bus.output_step_idx  = step_q;
  assign bus.output_wave_sel  = wave_q;
  assign bus.output_cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_dds_tuning_ctrl.sv
// Directed self-checking bench for dds_tuning_ctrl (debounce disabled build).
module tb_dds_tuning_ctrl;
  localparam int          FTW_W      = 32;
  localparam logic [31:0] TB_FTW_MAX = 32'd175000; // low ceiling so the upper clamp is reachable
  localparam int          HOLD       = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_tuning_ctrl_if #(.FTW_W(FTW_W)) bus ();

  dds_tuning_ctrl #(.FTW_W(FTW_W), .FTW_MAX(TB_FTW_MAX)) dut (
    .input_clk_27M (clk),
    .input_RESET_n (rst_n),
    .bus           (bus)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;

  always @(negedge clk) if (rst_n && bus.output_cfg_valid) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic ab(input logic [1:0] v);
    {bus.input_Rot_A, bus.input_Rot_B} = v;
    tick(HOLD);
  endtask

  task automatic cw();
    ab(2'b01); ab(2'b00); ab(2'b10); ab(2'b11);
  endtask

  task automatic ccw();
    ab(2'b10); ab(2'b00); ab(2'b01); ab(2'b11);
  endtask

  task automatic press_step();
    bus.input_BTN_step = 1'b1; tick(HOLD);
    bus.input_BTN_step = 1'b0; tick(HOLD);
  endtask

  initial begin
    bus.input_Rot_A = 1'b1; bus.input_Rot_B = 1'b1;
    bus.input_BTN_step = 1'b0; bus.input_BTN_mode = 4'b0000;
    tick(3);
    chk("rst_ftw", bus.output_ftw, 159073);
    chk("rst_wave", bus.output_wave_sel, 0);
    chk("rst_step", bus.output_step_idx, 0);
    chk("rst_valid", bus.output_cfg_valid, 0);
    rst_n = 1'b1; tick(HOLD);

    // CW detent at step 0
    p0 = pulses; cw();
    chk("cw_ftw", bus.output_ftw, 159074);
    chk("cw_pulses", pulses - p0, 1);

    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(HOLD);
    chk("rerst_ftw", bus.output_ftw, 159073);

    // Step x2 then CCW by 16, then wrap
    p0 = pulses; press_step(); press_step();
    chk("step2_idx", bus.output_step_idx, 2);
    chk("step2_pulses", pulses - p0, 2);
    p0 = pulses; ccw();
    chk("ccw_ftw", bus.output_ftw, 159057);
    chk("ccw_pulses", pulses - p0, 1);
    repeat (5) press_step();
    chk("step7_idx", bus.output_step_idx, 7);
    press_step();
    chk("step_wrap", bus.output_step_idx, 0);

    // Bounce tolerance, then illegal jump through ERR
    p0 = pulses;
    ab(2'b01); ab(2'b11); ab(2'b01); ab(2'b00); ab(2'b10); ab(2'b11);
    chk("bounce_ftw", bus.output_ftw, 159058);
    chk("bounce_pulses", pulses - p0, 1);
    p0 = pulses; ab(2'b00); ab(2'b11);
    chk("err_ftw", bus.output_ftw, 159058);
    chk("err_pulses", pulses - p0, 0);

    // Clamps at step 7 (16384 per detent)
    repeat (7) press_step();
    chk("clamp_step", bus.output_step_idx, 7);
    p0 = pulses; cw();
    chk("max_ftw", bus.output_ftw, 175000);
    chk("max_pulses", pulses - p0, 1);
    p0 = pulses; cw();
    chk("max_hold_ftw", bus.output_ftw, 175000);
    chk("max_hold_pulses", pulses - p0, 0);
    repeat (10) ccw();
    chk("down10_ftw", bus.output_ftw, 11160);
    p0 = pulses; ccw();
    chk("min_ftw", bus.output_ftw, 1);
    chk("min_pulses", pulses - p0, 1);
    p0 = pulses; ccw();
    chk("min_hold_ftw", bus.output_ftw, 1);
    chk("min_hold_pulses", pulses - p0, 0);

    // Mode buttons
    p0 = pulses; bus.input_BTN_mode = 4'b0110; tick(HOLD);
    chk("mode_wave", bus.output_wave_sel, 1);
    chk("mode_pulses", pulses - p0, 1);
    p0 = pulses; tick(HOLD); bus.input_BTN_mode = 4'b0000; tick(HOLD);
    chk("mode_rel_pulses", pulses - p0, 0);
    p0 = pulses; bus.input_BTN_mode = 4'b0010; tick(HOLD);
    bus.input_BTN_mode = 4'b0000; tick(HOLD);
    chk("mode_same_wave", bus.output_wave_sel, 1);
    chk("mode_same_pulses", pulses - p0, 0);

    // Mode press coincident with final detent edge
    p0 = pulses; ab(2'b01); ab(2'b00); ab(2'b10);
    {bus.input_Rot_A, bus.input_Rot_B} = 2'b11; bus.input_BTN_mode = 4'b1000; tick(HOLD);
    bus.input_BTN_mode = 4'b0000; tick(HOLD);
    chk("sim_mode_ftw", bus.output_ftw, 16385);
    chk("sim_mode_wave", bus.output_wave_sel, 3);
    chk("sim_mode_pulses", pulses - p0, 1);

    // Step press coincident with detent: old step size (16384) applies
    p0 = pulses; ab(2'b10); ab(2'b00); ab(2'b01);
    {bus.input_Rot_A, bus.input_Rot_B} = 2'b11; bus.input_BTN_step = 1'b1; tick(HOLD);
    bus.input_BTN_step = 1'b0; tick(HOLD);
    chk("sim_step_ftw", bus.output_ftw, 1);
    chk("sim_step_idx", bus.output_step_idx, 0);
    chk("sim_step_pulses", pulses - p0, 1);

    // Async reset mid-clock during a partial rotation
    ab(2'b01); ab(2'b00);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("arst_ftw", bus.output_ftw, 159073);
    chk("arst_wave", bus.output_wave_sel, 0);
    chk("arst_step", bus.output_step_idx, 0);
    chk("arst_valid", bus.output_cfg_valid, 0);
    tick(3);
    p0 = pulses; rst_n = 1'b1; tick(HOLD);
    ab(2'b10); ab(2'b11);
    chk("arst_partial_ftw", bus.output_ftw, 159073);
    chk("arst_partial_pulses", pulses - p0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
